// File: rtl/conv2d_window_scheduler.sv
// conv2d_window_scheduler
//
// Turns a row-major pixel stream into 3x3 windows for an external
// multiply/adder-tree datapath, then collects the datapath results in an
// output FIFO. The convolution is stride 1 with no padding, so each frame
// produces (IMG_H-2) x (IMG_W-2) results.
//
// Ports
//   clock       rising-edge clock for every flop
//   reset       asynchronous, active-low
//   start       one-cycle pulse that begins a frame (only honoured in IDLE)
//   in_valid    input pixel valid
//   in_ready    scheduler accepts a pixel this cycle
//   in_data     pixel, row-major order
//   win_valid   one-cycle strobe: win_data holds a complete window
//   win_data    9 pixels, element (r,c) at slice 3r+c, r=0 is the top row
//   res_data    datapath result, LATENCY cycles after win_valid
//   out_valid   FIFO head is valid
//   out_ready   downstream accepts the head
//   out_data    FIFO head (zero while the FIFO is empty)
//   out_last    head is the final result of the frame
//   busy        frame in progress (RUN or DRAIN)
//   frame_done  one-cycle pulse after the final result is accepted

module conv2d_window_scheduler #(
    parameter int bitWidth = 16,
    parameter int IMG_W    = 8,
    parameter int IMG_H    = 8,
    parameter int LATENCY  = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [bitWidth-1:0]   in_data,
    output logic                  win_valid,
    output logic [9*bitWidth-1:0] win_data,
    input  logic [bitWidth-1:0]   res_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [bitWidth-1:0]   out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int DEPTH = LATENCY + 2;
    localparam int CW    = $clog2(IMG_W);
    localparam int RW    = $clog2(IMG_H);
    localparam int PW    = $clog2(DEPTH);
    localparam int NW    = $clog2(DEPTH + 1);
    localparam int NW1   = NW + 1;

    localparam logic [CW-1:0]  LAST_COL     = CW'(IMG_W - 1);
    localparam logic [RW-1:0]  LAST_ROW     = RW'(IMG_H - 1);
    localparam logic [CW-1:0]  FIRST_WCOL   = CW'(2);
    localparam logic [RW-1:0]  FIRST_WROW   = RW'(2);
    localparam logic [PW-1:0]  LAST_PTR     = PW'(DEPTH - 1);
    localparam logic [NW1-1:0] CREDIT_LIMIT = NW1'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [RW-1:0] row;
    logic [CW-1:0] col;

    logic accept;
    logic at_last_pixel;
    logic accept_window;
    logic accept_final;

    // line_mid holds row i-1, line_top holds row i-2, indexed by column
    logic [bitWidth-1:0] line_mid [IMG_W];
    logic [bitWidth-1:0] line_top [IMG_W];
    logic [bitWidth-1:0] win      [3][3];

    logic               win_last;
    logic [LATENCY-1:0] valid_pipe;
    logic [LATENCY-1:0] last_pipe;
    logic               push;
    logic               push_last;
    logic               pop;
    logic               last_pop;

    logic [bitWidth-1:0] fifo_data [DEPTH];
    logic [DEPTH-1:0]    fifo_last;
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [NW-1:0]       occupancy;
    logic [NW-1:0]       in_flight;
    logic [NW1-1:0]      credit_used;

    // Handshake and position decode
    assign accept        = in_valid && in_ready;
    assign at_last_pixel = (row == LAST_ROW) && (col == LAST_COL);
    assign accept_window = accept && (row >= FIRST_WROW) && (col >= FIRST_WCOL);
    assign accept_final  = accept && at_last_pixel;

    // Every window that has been accepted but not yet pushed, plus every
    // result waiting in the FIFO, owns one FIFO slot. Holding off new pixels
    // once all slots are spoken for means the FIFO can never overflow even
    // though the datapath pipeline itself cannot be stalled.
    assign credit_used = {1'b0, in_flight} + {1'b0, occupancy};
    assign in_ready    = (state == RUN) && (credit_used < CREDIT_LIMIT);
    assign busy        = (state == RUN) || (state == DRAIN);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (accept_final) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (last_pop) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Pixel position; the last pixel wraps both counters back to the origin
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            row <= '0;
            col <= '0;
        end else if ((state == IDLE) && start) begin
            row <= '0;
            col <= '0;
        end else if (accept) begin
            if (col == LAST_COL) begin
                col <= '0;
                row <= (row == LAST_ROW) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Line buffers need no reset: rows 0 and 1 of every frame overwrite them
    // before any window reads them.
    always_ff @(posedge clock) begin
        if (accept) begin
            line_top[col] <= line_mid[col];
            line_mid[col] <= in_data;
        end
    end

    // Window shifts left by one column per accepted pixel; the new right-hand
    // column is (row i-2, row i-1, row i) at the current column.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= line_top[col];
            win[1][2] <= line_mid[col];
            win[2][2] <= in_data;
        end
    end

    always_comb begin
        win_data = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                win_data[(3*r+c)*bitWidth +: bitWidth] = win[r][c];
            end
        end
    end

    // win_valid lines up with the window register update. The valid/last
    // pipe mirrors the datapath latency so res_data is captured exactly
    // LATENCY cycles after its window was presented.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            win_valid  <= 1'b0;
            win_last   <= 1'b0;
            valid_pipe <= '0;
            last_pipe  <= '0;
        end else begin
            win_valid     <= accept_window;
            win_last      <= accept_window && at_last_pixel;
            valid_pipe[0] <= win_valid;
            last_pipe[0]  <= win_valid && win_last;
            for (int k = 1; k < LATENCY; k++) begin
                valid_pipe[k] <= valid_pipe[k-1];
                last_pipe[k]  <= last_pipe[k-1];
            end
        end
    end

    assign push      = valid_pipe[LATENCY-1];
    assign push_last = last_pipe[LATENCY-1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            in_flight <= '0;
        end else begin
            case ({accept_window, push})
                2'b10:   in_flight <= in_flight + 1'b1;
                2'b01:   in_flight <= in_flight - 1'b1;
                default: in_flight <= in_flight;
            endcase
        end
    end

    // Output FIFO
    assign out_valid = (occupancy != '0);
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? fifo_data[rd_ptr] : '0;
    assign out_last  = out_valid && fifo_last[rd_ptr];
    assign last_pop  = pop && out_last;

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_data[wr_ptr] <= res_data;
            fifo_last[wr_ptr] <= push_last;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= (state == DRAIN) && last_pop;
        end
    end

endmodule

// File: tb/tb_conv2d_window_scheduler.sv
// Directed testbench for conv2d_window_scheduler.
// dut  : 4x4 image, LATENCY 3 (main scenarios)
// dut2 : 4x4 image, LATENCY 1, FIFO of 3, small enough that back-pressure
//        exhausts the credit and stalls the pixel input.
// The datapath is modelled as a plain sum of the 9 window pixels.

module tb_conv2d_window_scheduler;

    localparam int BW  = 16;
    localparam int W   = 4;
    localparam int H   = 4;
    localparam int LAT = 3;

    logic clock = 1'b0;
    logic reset = 1'b0;

    logic            start     = 1'b0;
    logic            in_valid  = 1'b0;
    logic            in_ready;
    logic [BW-1:0]   in_data   = '0;
    logic            win_valid;
    logic [9*BW-1:0] win_data;
    logic [BW-1:0]   res_data;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [BW-1:0]   out_data;
    logic            out_last;
    logic            busy;
    logic            frame_done;

    logic            start2     = 1'b0;
    logic            in_valid2  = 1'b0;
    logic            in_ready2;
    logic [BW-1:0]   in_data2   = '0;
    logic            win_valid2;
    logic [9*BW-1:0] win_data2;
    logic [BW-1:0]   res_data2;
    logic            out_valid2;
    logic            out_ready2 = 1'b0;
    logic [BW-1:0]   out_data2;
    logic            out_last2;
    logic            busy2;
    logic            frame_done2;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [BW-1:0] exp_res [4] = '{16'd54, 16'd63, 16'd90, 16'd99};
    logic          exp_lst [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [BW-1:0] exp_br  [4] = '{16'd11, 16'd12, 16'd15, 16'd16};

    always #5 clock = ~clock;

    conv2d_window_scheduler #(
        .bitWidth(BW), .IMG_W(W), .IMG_H(H), .LATENCY(LAT)
    ) dut (
        .clock(clock), .reset(reset), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .win_valid(win_valid), .win_data(win_data), .res_data(res_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .frame_done(frame_done)
    );

    conv2d_window_scheduler #(
        .bitWidth(BW), .IMG_W(W), .IMG_H(H), .LATENCY(1)
    ) dut2 (
        .clock(clock), .reset(reset), .start(start2),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
        .win_valid(win_valid2), .win_data(win_data2), .res_data(res_data2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
        .out_last(out_last2), .busy(busy2), .frame_done(frame_done2)
    );

    // Datapath model: sum of the window, delayed by the configured latency
    function automatic logic [BW-1:0] window_sum(input logic [9*BW-1:0] w);
        logic [BW-1:0] s;
        s = '0;
        for (int k = 0; k < 9; k++) begin
            s = s + w[k*BW +: BW];
        end
        return s;
    endfunction

    logic [BW-1:0] pipe [LAT];
    logic [BW-1:0] pipe2;

    always @(posedge clock) begin
        pipe[0] <= window_sum(win_data);
        for (int k = 1; k < LAT; k++) begin
            pipe[k] <= pipe[k-1];
        end
        pipe2 <= window_sum(win_data2);
    end

    assign res_data  = pipe[LAT-1];
    assign res_data2 = pipe2;

    // Monitor: samples on the falling edge, records accepted results,
    // window strobes and frame_done timing.
    int            cyc = 0;
    logic [BW-1:0] got[$];
    logic          got_last[$];
    logic [BW-1:0] got2[$];
    logic [BW-1:0] win_br[$];
    int            win_count;
    int            done_count;
    int            last_pop_cyc;
    int            done_cyc;

    always @(negedge clock) begin
        cyc++;
        if (out_valid && out_ready) begin
            got.push_back(out_data);
            got_last.push_back(out_last);
            if (out_last) last_pop_cyc = cyc;
        end
        if (win_valid) begin
            win_count++;
            win_br.push_back(win_data[9*BW-1 -: BW]);
        end
        if (frame_done) begin
            done_count++;
            done_cyc = cyc;
        end
        if (out_valid2 && out_ready2) begin
            got2.push_back(out_data2);
        end
    end

    task automatic clear_log();
        got.delete();
        got_last.delete();
        got2.delete();
        win_br.delete();
        win_count    = 0;
        done_count   = 0;
        last_pop_cyc = -100;
        done_cyc     = -200;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    // Sends pixels 1..count on dut; toggle inserts an idle cycle before each
    // pixel; a nonzero start_at raises start together with that pixel.
    task automatic send_frame(input bit toggle, input int count, input int start_at);
        int  waited;
        bit  took;
        for (int p = 1; p <= count; p++) begin
            if (toggle) begin
                in_valid = 1'b0;
                @(posedge clock); #1;
            end
            in_valid = 1'b1;
            in_data  = BW'(p);
            start    = (p == start_at);
            waited   = 0;
            took     = 1'b0;
            while (!took && waited < 100) begin
                took = in_ready;
                @(posedge clock); #1;
                start = 1'b0;
                waited++;
            end
            tests_run++;
            if (!took) begin
                tests_failed++;
                $display("[TB] FAIL pixel_accept: pixel %0d not accepted, waited %0d cycles, required acceptance", p, waited);
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int k = 0; k < 200 && done_count == 0; k++) begin
            @(posedge clock); #1;
        end
        repeat (3) @(posedge clock);
        #1;
    endtask

    task automatic check_results(input string tag);
        tests_run++;
        if (got.size() !== 4) begin
            tests_failed++;
            $display("[TB] FAIL %s_count: got %0d results, expected 4", tag, got.size());
        end
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (k >= got.size()) begin
                tests_failed++;
                $display("[TB] FAIL %s_result[%0d]: missing, expected %0d", tag, k, exp_res[k]);
            end else if (got[k] !== exp_res[k] || got_last[k] !== exp_lst[k]) begin
                tests_failed++;
                $display("[TB] FAIL %s_result[%0d]: got %0d last=%b, expected %0d last=%b",
                         tag, k, got[k], got_last[k], exp_res[k], exp_lst[k]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        tests_run++;
        if ({in_ready, win_valid, out_valid, out_last, busy, frame_done} !== 6'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_flags: got %b, expected 000000",
                     {in_ready, win_valid, out_valid, out_last, busy, frame_done});
        end
        tests_run++;
        if (win_data !== '0 || out_data !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_data: win_data=%h out_data=%h, expected 0", win_data, out_data);
        end
        reset = 1'b1;
        @(posedge clock); #1;
        tests_run++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL idle_after_reset: busy=%b in_ready=%b, expected 0 0", busy, in_ready);
        end
    endtask

    task automatic test_stream();
        clear_log();
        out_ready = 1'b1;
        pulse_start();
        tests_run++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL run_entry: busy=%b in_ready=%b, expected 1 1", busy, in_ready);
        end
        send_frame(1'b0, 16, 0);
        wait_done();
        check_results("stream");
        tests_run++;
        if (done_count !== 1 || done_cyc !== last_pop_cyc + 1) begin
            tests_failed++;
            $display("[TB] FAIL frame_done_timing: pulses=%0d at cycle %0d, expected 1 at cycle %0d",
                     done_count, done_cyc, last_pop_cyc + 1);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL stream_idle: busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_backpressure();
        clear_log();
        out_ready = 1'b0;
        pulse_start();
        send_frame(1'b0, 16, 0);
        repeat (10) @(posedge clock);
        #1;
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 16'd54) begin
            tests_failed++;
            $display("[TB] FAIL bp_head: out_valid=%b out_data=%0d, expected 1 54", out_valid, out_data);
        end
        tests_run++;
        if (busy !== 1'b1 || in_ready !== 1'b0 || got.size() !== 0) begin
            tests_failed++;
            $display("[TB] FAIL bp_drain_hold: busy=%b in_ready=%b popped=%0d, expected 1 0 0",
                     busy, in_ready, got.size());
        end
        repeat (5) @(posedge clock);
        #1;
        tests_run++;
        if (out_data !== 16'd54 || out_last !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL bp_stable: out_data=%0d out_last=%b, expected 54 0", out_data, out_last);
        end
        out_ready = 1'b1;
        wait_done();
        check_results("bp");
        tests_run++;
        if (out_valid !== 1'b0 || done_count !== 1) begin
            tests_failed++;
            $display("[TB] FAIL bp_empty: out_valid=%b frame_done pulses=%0d, expected 0 1", out_valid, done_count);
        end
    endtask

    task automatic test_toggle();
        clear_log();
        out_ready = 1'b1;
        pulse_start();
        send_frame(1'b1, 16, 0);
        wait_done();
        check_results("toggle");
        tests_run++;
        if (win_count !== 4) begin
            tests_failed++;
            $display("[TB] FAIL win_count: got %0d, expected 4", win_count);
        end
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (k >= win_br.size() || win_br[k] !== exp_br[k]) begin
                tests_failed++;
                $display("[TB] FAIL win_position[%0d]: bottom-right pixel %0d, expected %0d",
                         k, (k < win_br.size()) ? win_br[k] : 16'hffff, exp_br[k]);
            end
        end
    endtask

    task automatic test_start_ignored();
        clear_log();
        out_ready = 1'b1;
        pulse_start();
        send_frame(1'b0, 16, 8);
        wait_done();
        check_results("start_in_run");
        clear_log();
        pulse_start();
        send_frame(1'b0, 16, 0);
        wait_done();
        check_results("second_frame");
        tests_run++;
        if (done_count !== 1) begin
            tests_failed++;
            $display("[TB] FAIL second_frame_done: pulses=%0d, expected 1", done_count);
        end
    endtask

    // dut2 has only 3 FIFO slots, so with out_ready2 low the third window
    // exhausts the credit and pixel 16 must wait.
    task automatic test_credit();
        int  waited;
        bit  took;
        clear_log();
        out_ready2 = 1'b0;
        start2 = 1'b1;
        @(posedge clock); #1;
        start2 = 1'b0;
        for (int p = 1; p <= 15; p++) begin
            in_valid2 = 1'b1;
            in_data2  = BW'(p);
            waited    = 0;
            took      = 1'b0;
            while (!took && waited < 100) begin
                took = in_ready2;
                @(posedge clock); #1;
                waited++;
            end
            if (!took) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL credit_accept: pixel %0d not accepted, required acceptance", p);
                break;
            end
        end
        in_data2 = BW'(16);
        repeat (6) @(posedge clock);
        #1;
        tests_run++;
        if (in_ready2 !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL credit_stall: in_ready=%b with full credit, expected 0", in_ready2);
        end
        tests_run++;
        if (out_valid2 !== 1'b1 || out_data2 !== 16'd54) begin
            tests_failed++;
            $display("[TB] FAIL credit_head: out_valid=%b out_data=%0d, expected 1 54", out_valid2, out_data2);
        end
        out_ready2 = 1'b1;
        waited = 0;
        took   = 1'b0;
        while (!took && waited < 100) begin
            took = in_ready2;
            @(posedge clock); #1;
            waited++;
        end
        in_valid2 = 1'b0;
        for (int k = 0; k < 100 && busy2; k++) begin
            @(posedge clock); #1;
        end
        repeat (5) @(posedge clock);
        #1;
        tests_run++;
        if (got2.size() !== 4) begin
            tests_failed++;
            $display("[TB] FAIL credit_count: got %0d results, expected 4", got2.size());
        end
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (k >= got2.size() || got2[k] !== exp_res[k]) begin
                tests_failed++;
                $display("[TB] FAIL credit_result[%0d]: got %0d, expected %0d",
                         k, (k < got2.size()) ? got2[k] : 16'hffff, exp_res[k]);
            end
        end
        out_ready2 = 1'b0;
    endtask

    task automatic test_reset_midframe();
        out_ready = 1'b1;
        pulse_start();
        send_frame(1'b0, 12, 0);
        reset = 1'b0;
        #1;
        tests_run++;
        if ({in_ready, win_valid, out_valid, out_last, busy, frame_done} !== 6'b0 ||
            win_data !== '0 || out_data !== '0) begin
            tests_failed++;
            $display("[TB] FAIL midframe_reset: flags=%b win_data=%h out_data=%h, expected all 0",
                     {in_ready, win_valid, out_valid, out_last, busy, frame_done}, win_data, out_data);
        end
        repeat (2) @(posedge clock);
        #1;
        clear_log();
        reset = 1'b1;
        repeat (12) @(posedge clock);
        #1;
        tests_run++;
        if (got.size() !== 0 || out_valid !== 1'b0 || win_count !== 0) begin
            tests_failed++;
            $display("[TB] FAIL stale_results: popped=%0d out_valid=%b windows=%0d, expected 0 0 0",
                     got.size(), out_valid, win_count);
        end
        pulse_start();
        send_frame(1'b0, 16, 0);
        wait_done();
        check_results("after_reset");
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_toggle();
        test_start_ignored();
        test_credit();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
